// File: rtl/instr_loader.sv
// Boot-time instruction loader. Receives a framed byte stream
// (sync, length, payload, checksum), writes the payload into instruction
// memory and releases the CPU only after a frame with a good checksum.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | after reset; hunting for the sync byte, CPU held
// S_LEN   | sync seen; waiting for the length byte
// S_DATA  | waiting for the next payload byte
// S_WRITE | one-cycle memory write of the byte captured in S_DATA
// S_CHK   | all payload written; waiting for the checksum byte
// S_DONE  | checksum matched; CPU running, a new sync restarts loading
// S_ERR   | checksum mismatch or inter-byte timeout; hunting for sync
module instr_loader #(
   parameter logic [7:0]  SYNC_BYTE = 8'hA5,
   parameter logic [15:0] TIMEOUT   = 16'd50000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       mem_we,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       cpu_run,
   output logic       busy,
   output logic       err
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
   } state_t;

   state_t      state, state_nx;
   logic [7:0]  addr_cnt;
   logic [7:0]  csum;
   logic [8:0]  remain;
   logic [15:0] idle_cnt;
   logic        xfer;
   logic        is_sync;
   logic        timed_out;

   assign xfer      = in_valid && in_ready;
   assign is_sync   = (in_data == SYNC_BYTE);
   // The edge that would bring the idle count up to TIMEOUT is the timeout
   // edge; a transfer on that same edge takes priority in the FSM.
   assign timed_out = (idle_cnt == TIMEOUT - 16'd1);

   // State register
   always_ff @(posedge clock) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nx;
   end

   // Next-state and Moore outputs
   always_comb begin
      state_nx = state;
      in_ready = 1'b1;
      mem_we   = 1'b0;
      cpu_run  = 1'b0;
      busy     = 1'b0;
      err      = 1'b0;
      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            cpu_run = (state == S_DONE);
            err     = (state == S_ERR);
            if (xfer && is_sync) state_nx = S_LEN;
         end
         S_LEN: begin
            busy = 1'b1;
            if (xfer)           state_nx = S_DATA;
            else if (timed_out) state_nx = S_ERR;
         end
         S_DATA: begin
            busy = 1'b1;
            if (xfer)           state_nx = S_WRITE;
            else if (timed_out) state_nx = S_ERR;
         end
         S_WRITE: begin
            busy     = 1'b1;
            in_ready = 1'b0;
            mem_we   = 1'b1;
            state_nx = (remain == 9'd1) ? S_CHK : S_DATA;
         end
         S_CHK: begin
            busy = 1'b1;
            if (xfer)           state_nx = (in_data == csum) ? S_DONE : S_ERR;
            else if (timed_out) state_nx = S_ERR;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Datapath: address/length/checksum bookkeeping and the memory write port
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         addr_cnt  <= 8'd0;
         csum      <= 8'd0;
         remain    <= 9'd0;
         mem_addr  <= 8'd0;
         mem_wdata <= 8'd0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (xfer && is_sync) begin
                  addr_cnt <= 8'd0;
                  csum     <= 8'd0;
               end
            end
            S_LEN: begin
               if (xfer) remain <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            end
            S_DATA: begin
               if (xfer) begin
                  mem_wdata <= in_data;
                  mem_addr  <= addr_cnt;
                  csum      <= csum + in_data;
               end
            end
            S_WRITE: begin
               addr_cnt <= addr_cnt + 8'd1;
               remain   <= remain - 9'd1;
            end
            default: ;
         endcase
      end
   end

   // Inter-byte idle counter, live only while a frame is waiting for input
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         idle_cnt <= 16'd0;
      end else if ((state == S_LEN || state == S_DATA || state == S_CHK) && !xfer) begin
         idle_cnt <= idle_cnt + 16'd1;
      end else begin
         idle_cnt <= 16'd0;
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader: frames are built from the byte-level
// frame rules, memory writes are collected by a monitor and compared to the
// payload expected at each address.
module tb_instr_loader;

   localparam logic [7:0] SYNC = 8'hA5;
   localparam int         TMO  = 10;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready, mem_we, cpu_run, busy, err;
   logic [7:0] mem_addr, mem_wdata;

   instr_loader #(.SYNC_BYTE(SYNC), .TIMEOUT(16'd10)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .cpu_run  (cpu_run),
      .busy     (busy),
      .err      (err)
   );

   always #5 clock = ~clock;

   int          n_err = 0;
   int          n_chk = 0;
   int          stall_cnt = 0;
   logic [15:0] wr_q[$];
   logic [7:0]  hold_addr = 8'h00;
   logic [7:0]  hold_data = 8'h00;
   logic        prev_we = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Write-port monitor: capture writes, check pulse width and hold behaviour
   always @(negedge clock) begin
      if (!reset_n) begin
         hold_addr = 8'h00;
         hold_data = 8'h00;
         prev_we   = 1'b0;
      end else if (mem_we) begin
         check_val("we_pulse_width", prev_we, 1'b0);
         check_val("ready_in_write", in_ready, 1'b0);
         wr_q.push_back({mem_addr, mem_wdata});
         hold_addr = mem_addr;
         hold_data = mem_wdata;
         prev_we   = 1'b1;
      end else begin
         check_val("addr_hold", mem_addr, hold_addr);
         check_val("wdata_hold", mem_wdata, hold_data);
         prev_we = 1'b0;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int guard = 0;
      in_data  = b;
      in_valid = 1'b1;
      @(negedge clock);
      while (!in_ready && guard < 8) begin
         stall_cnt++;
         guard++;
         @(negedge clock);
      end
      if (!in_ready) check_val("handshake_bound", in_ready, 1'b1);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   function automatic int pick_gap(input int gap_max);
      return (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0));
   endfunction

   task automatic send_frame(input logic [7:0] lenb, input logic [7:0] pay[$],
                             input logic [7:0] chkb, input int gap_max);
      send_byte(SYNC);
      idle(pick_gap(gap_max));
      send_byte(lenb);
      foreach (pay[i]) begin
         idle(pick_gap(gap_max));
         send_byte(pay[i]);
      end
      idle(pick_gap(gap_max));
      send_byte(chkb);
   endtask

   // Reference: payload byte i lands at address i (mod 256); the frame is
   // accepted exactly when the mod-256 payload sum equals the check byte.
   task automatic check_frame(input string tag, input logic [7:0] pay[$], input logic [7:0] chkb);
      logic [7:0] sum = 8'h00;
      logic       ok;
      int         n;
      foreach (pay[i]) sum = sum + pay[i];
      ok = (sum == chkb);
      check_val({tag, "_nwrites"}, wr_q.size(), pay.size());
      n = (wr_q.size() < pay.size()) ? wr_q.size() : pay.size();
      for (int i = 0; i < n; i++) check_val({tag, "_write"}, wr_q[i], {i[7:0], pay[i]});
      check_val({tag, "_cpu_run"}, cpu_run, ok);
      check_val({tag, "_err"}, err, !ok);
      check_val({tag, "_busy"}, busy, 1'b0);
      check_val({tag, "_in_ready"}, in_ready, 1'b1);
      wr_q.delete();
   endtask

   task automatic check_reset_outs(input string tag);
      check_val({tag, "_in_ready"}, in_ready, 1'b1);
      check_val({tag, "_mem_we"}, mem_we, 1'b0);
      check_val({tag, "_mem_addr"}, mem_addr, 8'h00);
      check_val({tag, "_mem_wdata"}, mem_wdata, 8'h00);
      check_val({tag, "_cpu_run"}, cpu_run, 1'b0);
      check_val({tag, "_busy"}, busy, 1'b0);
      check_val({tag, "_err"}, err, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [7:0] pay[$];
      logic [7:0] chkb;
      logic [7:0] sum;
      int         len;

      reset_n = 1'b0;
      idle(2);
      check_reset_outs("reset");
      reset_n = 1'b1;

      // Known-good frame
      pay = {8'h11, 8'h22, 8'h33};
      send_frame(8'h03, pay, 8'h66, 2);
      check_frame("good", pay, 8'h66);

      // Bad checksum, then a sync byte clears the error and restarts
      pay = {8'h10, 8'h20};
      send_frame(8'h02, pay, 8'h31, 1);
      check_frame("badchk", pay, 8'h31);
      send_byte(SYNC);
      check_val("resync_err", err, 1'b0);
      check_val("resync_busy", busy, 1'b1);
      check_val("resync_cpu_run", cpu_run, 1'b0);
      send_byte(8'h01);
      send_byte(8'h07);
      send_byte(8'h07);
      pay = {8'h07};
      check_frame("resync", pay, 8'h07);

      // Leading noise, then continuous in_valid: one stall per write
      send_byte(8'h00);
      send_byte(8'hFF);
      check_val("noise_nwrites", wr_q.size(), 0);
      check_val("noise_cpu_run", cpu_run, 1'b1);
      pay.delete();
      for (int i = 0; i < 5; i++) pay.push_back(8'($urandom_range(255, 0)));
      sum = 8'h00;
      foreach (pay[i]) sum = sum + pay[i];
      stall_cnt = 0;
      send_frame(8'h05, pay, sum, 0);
      check_val("backpressure_stalls", stall_cnt, 5);
      check_frame("backpressure", pay, sum);

      // LEN=0 means 256 bytes; addresses cover the whole 8-bit range
      pay.delete();
      for (int i = 0; i < 256; i++) pay.push_back(8'h01);
      send_frame(8'h00, pay, 8'h00, 0);
      check_frame("len256", pay, 8'h00);

      // Transfer on the last allowed idle cycle wins over the timeout
      send_byte(SYNC);
      send_byte(8'h01);
      idle(TMO - 1);
      send_byte(8'h3C);
      send_byte(8'h3C);
      pay = {8'h3C};
      check_frame("tmo_edge", pay, 8'h3C);

      // Timeout inside DATA after one write
      send_byte(SYNC);
      send_byte(8'h04);
      send_byte(8'hAA);
      idle(TMO);
      check_val("tmo_pre_err", err, 1'b0);
      check_val("tmo_pre_busy", busy, 1'b1);
      idle(1);
      check_val("tmo_err", err, 1'b1);
      check_val("tmo_busy", busy, 1'b0);
      check_val("tmo_cpu_run", cpu_run, 1'b0);
      check_val("tmo_nwrites", wr_q.size(), 1);
      if (wr_q.size() > 0) check_val("tmo_write", wr_q[0], {8'h00, 8'hAA});
      wr_q.delete();

      // Reset while in DATA, then a fresh good frame
      send_byte(SYNC);
      send_byte(8'h03);
      send_byte(8'h11);
      idle(1);
      reset_n = 1'b0;
      idle(1);
      check_reset_outs("midreset");
      reset_n = 1'b1;
      wr_q.delete();
      pay = {8'h5A, 8'hA5, 8'h01};
      send_frame(8'h03, pay, 8'h00, 1);
      check_frame("after_reset", pay, 8'h00);

      // Randomized frames with noise, gaps and occasional bad checksums
      for (int f = 0; f < 10; f++) begin
         for (int k = 0; k < int'($urandom_range(3, 0)); k++) begin
            logic [7:0] nb;
            nb = 8'($urandom_range(255, 0));
            if (nb == SYNC) nb = 8'h00;
            send_byte(nb);
         end
         len = int'($urandom_range(24, 1));
         pay.delete();
         for (int i = 0; i < len; i++) pay.push_back(8'($urandom_range(255, 0)));
         sum = 8'h00;
         foreach (pay[i]) sum = sum + pay[i];
         chkb = ($urandom_range(3, 0) == 0) ? (sum ^ 8'($urandom_range(255, 1))) : sum;
         send_frame(8'(len), pay, chkb, 4);
         check_frame("random", pay, chkb);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
